// File: rtl/fp_rnd_pipe.sv
// Rounding/packing back-end for FPU front-end records.
// Stage 1 applies the rounding increment to the significand; stage 2
// renormalises, detects overflow/underflow, resolves special values and packs
// an IEEE-754 single or double result with its exception flags.
module fp_rnd_pipe #(
  parameter bit RISCV = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sig,
  input  logic [13:0] in_expo,
  input  logic [53:0] in_mant,
  input  logic [1:0]  in_rema,
  input  logic [1:0]  in_fmt,
  input  logic [2:0]  in_rm,
  input  logic [2:0]  in_grs,
  input  logic        in_snan,
  input  logic        in_qnan,
  input  logic        in_dbz,
  input  logic        in_infs,
  input  logic        in_zero,
  input  logic        in_diff,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_flags
);

  localparam logic [2:0]  RM_RNE = 3'd0;
  localparam logic [2:0]  RM_RTZ = 3'd1;
  localparam logic [2:0]  RM_RDN = 3'd2;
  localparam logic [2:0]  RM_RUP = 3'd3;
  localparam logic [2:0]  RM_RMM = 3'd4;
  localparam logic [31:0] FILL   = RISCV ? 32'hFFFF_FFFF : 32'h0000_0000;

  // Stage-1 registers
  logic        r_s1_valid, r_s1_sig, r_s1_dbl, r_s1_inx;
  logic [13:0] r_s1_expo;
  logic [53:0] r_s1_m;
  logic [2:0]  r_s1_rm;
  logic        r_s1_snan, r_s1_qnan, r_s1_dbz, r_s1_infs, r_s1_zero, r_s1_diff;

  // Output registers
  logic        r_out_valid;
  logic [63:0] r_out_result;
  logic [4:0]  r_out_flags;

  // Stage-1 combinational
  logic        w_dbl, w_inx, w_inc, w_s2_adv;
  logic [53:0] w_mw, w_sum, w_m1;

  // Stage-2 combinational
  logic        w_carry, w_hid, w_of, w_inf_sel, w_uf, w_sgn;
  logic [53:0] w_mn;
  logic [14:0] w_e1, w_e2, w_emax;
  logic [10:0] w_e_fld;
  logic [51:0] w_frac, w_fmask;
  logic [63:0] w_res;
  logic [4:0]  w_flg;
  logic        w_unused;

  assign w_s2_adv   = ~r_out_valid | out_ready;
  assign in_ready   = ~r_s1_valid | w_s2_adv;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

  // Formats 2/3 behave as double; single keeps W+1 = 25 significand bits.
  assign w_dbl = (in_fmt != 2'd0);
  assign w_mw  = w_dbl ? in_mant : {29'd0, in_mant[24:0]};
  assign w_inx = |in_grs;

  // Rounding increment chosen by rounding mode; reserved modes truncate.
  always_comb begin
    w_inc = 1'b0;
    case (in_rm)
      RM_RNE:  w_inc = in_grs[2] & (in_mant[0] | in_grs[1] | in_grs[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = in_sig & w_inx;
      RM_RUP:  w_inc = ~in_sig & w_inx;
      RM_RMM:  w_inc = in_grs[2];
      default: w_inc = 1'b0;
    endcase
  end

  assign w_sum = w_mw + {53'd0, w_inc};
  assign w_m1  = w_dbl ? w_sum : {29'd0, w_sum[24:0]};

  // Stage 1: capture the rounded significand and the qualifiers needed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sig   <= 1'b0;
      r_s1_dbl   <= 1'b0;
      r_s1_inx   <= 1'b0;
      r_s1_expo  <= '0;
      r_s1_m     <= '0;
      r_s1_rm    <= '0;
      r_s1_snan  <= 1'b0;
      r_s1_qnan  <= 1'b0;
      r_s1_dbz   <= 1'b0;
      r_s1_infs  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_diff  <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sig  <= in_sig;
        r_s1_dbl  <= w_dbl;
        r_s1_inx  <= w_inx;
        r_s1_expo <= in_expo;
        r_s1_m    <= w_m1;
        r_s1_rm   <= in_rm;
        r_s1_snan <= in_snan;
        r_s1_qnan <= in_qnan;
        r_s1_dbz  <= in_dbz;
        r_s1_infs <= in_infs;
        r_s1_zero <= in_zero;
        r_s1_diff <= in_diff;
      end
    end
  end

  // A carry out of the significand shifts it back and bumps the exponent;
  // a subnormal that rounded up to the hidden bit becomes the smallest normal.
  assign w_carry   = r_s1_dbl ? r_s1_m[53] : r_s1_m[24];
  assign w_mn      = w_carry ? (r_s1_m >> 1) : r_s1_m;
  assign w_e1      = {1'b0, r_s1_expo} + {14'd0, w_carry};
  assign w_hid     = r_s1_dbl ? w_mn[52] : w_mn[23];
  assign w_e2      = ((w_e1 == 15'd0) && w_hid) ? 15'd1 : w_e1;
  assign w_emax    = r_s1_dbl ? 15'd2047 : 15'd255;
  assign w_of      = (w_e2 >= w_emax);
  assign w_inf_sel = (r_s1_rm == RM_RNE) | (r_s1_rm == RM_RMM) |
                     ((r_s1_rm == RM_RUP) & ~r_s1_sig) | ((r_s1_rm == RM_RDN) & r_s1_sig);
  assign w_uf      = (r_s1_expo == 14'd0) & r_s1_inx;
  assign w_fmask   = r_s1_dbl ? {52{1'b1}} : {29'd0, {23{1'b1}}};
  assign w_unused  = ^{in_rema, w_mn[53]};

  // Stage-2 result selection: overflow saturation, then special-value override.
  always_comb begin
    w_sgn   = r_s1_sig;
    w_e_fld = w_e2[10:0];
    w_frac  = w_mn[51:0] & w_fmask;
    w_flg   = {2'b00, w_of, w_uf, r_s1_inx | w_of};
    if (w_of) begin
      if (w_inf_sel) begin
        w_e_fld = w_emax[10:0];
        w_frac  = '0;
      end else begin
        w_e_fld = w_emax[10:0] - 11'd1;
        w_frac  = w_fmask;
      end
    end
    if (r_s1_snan || r_s1_qnan) begin
      w_sgn   = 1'b0;
      w_e_fld = w_emax[10:0];
      w_frac  = r_s1_dbl ? 52'h8_0000_0000_0000 : 52'h0_0000_0040_0000;
      w_flg   = {r_s1_snan, 4'b0000};
    end else if (r_s1_infs || r_s1_dbz) begin
      w_e_fld = w_emax[10:0];
      w_frac  = '0;
      w_flg   = {1'b0, r_s1_dbz, 3'b000};
    end else if (r_s1_zero) begin
      w_sgn   = r_s1_diff ? (r_s1_rm == RM_RDN) : r_s1_sig;
      w_e_fld = '0;
      w_frac  = '0;
      w_flg   = '0;
    end
    w_res = r_s1_dbl ? {w_sgn, w_e_fld, w_frac}
                     : {FILL, w_sgn, w_e_fld[7:0], w_frac[22:0]};
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_res;
        r_out_flags  <= w_flg;
      end
    end
  end

endmodule
